// File: rtl/writeback_unit_if.sv
// Handshake and register-file bundle for writeback_unit: ALU/load result inputs,
// register-file write port, decode-stage hazard probe, flush and occupancy.
interface writeback_unit_if;
  logic       alu_valid;
  logic       alu_ready;
  logic [2:0] alu_target;
  logic [7:0] alu_data;
  logic       ld_valid;
  logic       ld_ready;
  logic [2:0] ld_target;
  logic [7:0] ld_data;
  logic       readWrite;
  logic [2:0] target;
  logic [7:0] writeData;
  logic [2:0] chk_regA;
  logic [2:0] chk_regB;
  logic       hazard;
  logic       flush;
  logic [2:0] count;

  modport master (
    output alu_valid, alu_target, alu_data,
    output ld_valid, ld_target, ld_data,
    output chk_regA, chk_regB, flush,
    input  alu_ready, ld_ready, readWrite, target, writeData, hazard, count
  );

  modport slave (
    input  alu_valid, alu_target, alu_data,
    input  ld_valid, ld_target, ld_data,
    input  chk_regA, chk_regB, flush,
    output alu_ready, ld_ready, readWrite, target, writeData, hazard, count
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback merge: 4-entry in-order FIFO feeding the register-file write port from
// ALU and load results. Define WB_SCOREBOARD_EN to build the pending-write hazard compare.
module writeback_unit (
  input logic             clk,
  input logic             rst_n,
  writeback_unit_if.slave bus
);

  logic [10:0] mem [4];
  logic [2:0]  occ;
  logic [1:0]  rdPtr;
  logic [1:0]  wrPtr;
  logic [2:0]  space;
  logic        aluRdy;
  logic        ldRdy;
  logic        pop;
  logic        aluPush;
  logic        ldPush;
  logic [1:0]  ldSlot;
  logic        readWriteQ;
  logic [2:0]  targetQ;
  logic [7:0]  writeDataQ;

  // Space counts the head slot as free whenever it will be popped this same edge.
  always_comb begin
    space   = 3'd4 - occ + {2'b00, occ != 3'd0};
    aluRdy  = (space >= 3'd1) && !bus.flush;
    ldRdy   = ((space >= 3'd2) || ((space >= 3'd1) && !bus.alu_valid)) && !bus.flush;
    pop     = (occ != 3'd0) && !bus.flush;
    aluPush = bus.alu_valid && aluRdy && (bus.alu_target != 3'd0);
    ldPush  = bus.ld_valid && ldRdy && (bus.ld_target != 3'd0);
    ldSlot  = wrPtr + {1'b0, aluPush};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ        <= 3'd0;
      rdPtr      <= 2'd0;
      wrPtr      <= 2'd0;
      readWriteQ <= 1'b0;
      targetQ    <= 3'd0;
      writeDataQ <= 8'd0;
    end else if (bus.flush) begin
      occ        <= 3'd0;
      rdPtr      <= 2'd0;
      wrPtr      <= 2'd0;
      readWriteQ <= 1'b0;
    end else begin
      readWriteQ <= pop;
      if (pop) begin
        targetQ    <= mem[rdPtr][10:8];
        writeDataQ <= mem[rdPtr][7:0];
      end
      rdPtr <= rdPtr + {1'b0, pop};
      wrPtr <= wrPtr + {1'b0, aluPush} + {1'b0, ldPush};
      occ   <= occ + {2'b00, aluPush} + {2'b00, ldPush} - {2'b00, pop};
    end
  end

  // ALU entry takes the lower slot so it drains ahead of a same-cycle load.
  always_ff @(posedge clk) begin
    if (aluPush) mem[wrPtr] <= {bus.alu_target, bus.alu_data};
    if (ldPush)  mem[ldSlot] <= {bus.ld_target, bus.ld_data};
  end

`ifdef WB_SCOREBOARD_EN
  logic       hazardC;
  logic [2:0] slotTgt;
  always_comb begin
    hazardC = 1'b0;
    slotTgt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      slotTgt = mem[rdPtr + 2'(i)][10:8];
      if ((3'(i) < occ) &&
          (((bus.chk_regA != 3'd0) && (slotTgt == bus.chk_regA)) ||
           ((bus.chk_regB != 3'd0) && (slotTgt == bus.chk_regB))))
        hazardC = 1'b1;
    end
  end
  assign bus.hazard = hazardC;
`else
  logic unusedChk;
  assign unusedChk  = ^{bus.chk_regA, bus.chk_regB};
  assign bus.hazard = 1'b0;
`endif

  assign bus.alu_ready = aluRdy;
  assign bus.ld_ready  = ldRdy;
  assign bus.readWrite = readWriteQ;
  assign bus.target    = targetQ;
  assign bus.writeData = writeDataQ;
  assign bus.count     = occ;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios then random traffic against a queue model.
module tb_writeback_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  writeback_unit_if bus ();

  writeback_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [10:0] q[$];
  logic        expRw   = 1'b0;
  logic [2:0]  expTgt  = 3'd0;
  logic [7:0]  expData = 8'd0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit modelHazard(input logic [2:0] ca, input logic [2:0] cb);
    bit h = 1'b0;
`ifdef WB_SCOREBOARD_EN
    foreach (q[i])
      if ((ca != 0 && q[i][10:8] == ca) || (cb != 0 && q[i][10:8] == cb)) h = 1'b1;
`endif
    return h;
  endfunction

  task automatic cycle(input bit av, input logic [2:0] at, input logic [7:0] ad,
                       input bit lv, input logic [2:0] lt, input logic [7:0] ld,
                       input bit fl, input logic [2:0] ca, input logic [2:0] cb);
    int  space;
    bit  expAr;
    bit  expLr;
    @(negedge clk);
    bus.alu_valid = av; bus.alu_target = at; bus.alu_data = ad;
    bus.ld_valid  = lv; bus.ld_target  = lt; bus.ld_data  = ld;
    bus.flush = fl; bus.chk_regA = ca; bus.chk_regB = cb;
    #1;
    space = 4 - q.size() + ((q.size() != 0) ? 1 : 0);
    expAr = (space >= 1) && !fl;
    expLr = ((space >= 2) || (space >= 1 && !av)) && !fl;
    check("alu_ready", bus.alu_ready, expAr);
    check("ld_ready",  bus.ld_ready,  expLr);
    check("count",     bus.count,     q.size());
    check("readWrite", bus.readWrite, expRw);
    check("target",    bus.target,    expTgt);
    check("writeData", bus.writeData, expData);
    check("hazard",    bus.hazard,    modelHazard(ca, cb));
    @(posedge clk);
    if (fl) begin
      q.delete();
      expRw = 1'b0;
    end else begin
      if (q.size() != 0) begin
        logic [10:0] head = q.pop_front();
        expRw = 1'b1; expTgt = head[10:8]; expData = head[7:0];
      end else begin
        expRw = 1'b0;
      end
      if (av && expAr && at != 0) q.push_back({at, ad});
      if (lv && expLr && lt != 0) q.push_back({lt, ld});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkCleared(input string tag);
    check({tag, "_readWrite"}, bus.readWrite, 0);
    check({tag, "_target"},    bus.target,    0);
    check({tag, "_writeData"}, bus.writeData, 0);
    check({tag, "_count"},     bus.count,     0);
    check({tag, "_alu_ready"}, bus.alu_ready, 1);
    check({tag, "_hazard"},    bus.hazard,    0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.alu_valid = 0; bus.alu_target = 0; bus.alu_data = 0;
    bus.ld_valid  = 0; bus.ld_target  = 0; bus.ld_data  = 0;
    bus.flush = 0; bus.chk_regA = 0; bus.chk_regB = 0;
    #12;
    checkCleared("reset");
    check("reset_ld_ready", bus.ld_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single write with one-cycle pulse.
    cycle(1, 3'd3, 8'h5A, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Dual push: ALU drains ahead of load.
    cycle(1, 3'd2, 8'h11, 1, 3'd5, 8'h22, 0, 0, 0);
    idle(4);

    // Back-to-back ALU with loads pending throughout.
    for (int i = 0; i < 6; i++)
      cycle(1, 3'(1 + (i % 7)), 8'(8'h30 + i), 1, 3'(7 - (i % 6)), 8'(8'h70 + i), 0, 0, 0);
    idle(8);

    // r0 writes are swallowed.
    cycle(1, 3'd0, 8'hFF, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Hazard probe against queued targets.
    cycle(1, 3'd4, 8'h44, 1, 3'd1, 8'h01, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 3'd4, 3'd0);
    cycle(1, 3'd4, 8'h45, 1, 3'd2, 8'h02, 0, 3'd0, 3'd6);
    cycle(0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd2);
    idle(4);

    // Flush with three queued entries.
    cycle(1, 3'd1, 8'hA1, 1, 3'd2, 8'hA2, 0, 0, 0);
    cycle(1, 3'd3, 8'hA3, 1, 3'd4, 8'hA4, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 3'd3, 3'd4);
    idle(3);

    // Asynchronous reset between edges.
    cycle(1, 3'd5, 8'hB5, 1, 3'd6, 8'hB6, 0, 0, 0);
    cycle(1, 3'd7, 8'hB7, 1, 3'd1, 8'hB1, 0, 0, 0);
    @(negedge clk);
    bus.alu_valid = 0; bus.ld_valid = 0; bus.chk_regA = 3'd7; bus.chk_regB = 3'd1;
    #2;
    rst_n = 1'b0;
    #1;
    checkCleared("async_reset");
    q.delete(); expRw = 0; expTgt = 0; expData = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
            ($urandom_range(0, 19) == 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
